mult_booth_seq: RTL

MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

---
 rtl/mult_booth_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: 32x32 signed radix-2 Booth sequential multiplier; define MULT_OVERFLOW_DETECT_EN for the overflow flag.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       gp,
  output logic       gg
);
  logic [7:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  assign s = p ^ c;
  assign gp = &p;
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 7; i++) c[i+1] = g[i] | (p[i] & c[i]);
    gg = 1'b0;
    for (int i = 0; i < 8; i++) gg = g[i] | (p[i] & gg);
  end
endmodule

module mult_booth_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        data_exception,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] a, y, s;
  logic [64:0] prod;
  logic [4:0]  cnt, c;
  logic [3:0]  gp, gg;
  logic [32:0] sum;
  logic        sub, add_en;
  assign add_en = prod[1] ^ prod[0];
  assign sub = prod[1] & ~prod[0];
  assign y = add_en ? (sub ? ~a : a) : 32'd0;
  assign c[0] = sub;
  assign c[1] = gg[0] | (gp[0] & c[0]);
  assign c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
  assign c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
  assign c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
  for (genvar i = 0; i < 4; i++) begin : g_cla
    cla8 u_cla (
      .a   (prod[33+8*i +: 8]),
      .b   (y[8*i +: 8]),
      .cin (c[i]),
      .s   (s[8*i +: 8]),
      .gp  (gp[i]),
      .gg  (gg[i])
    );
  end
  // 33rd bit sign-extends both operands so subtracting 0x80000000 cannot overflow
  assign sum = {prod[64] ^ y[31] ^ c[4], s};
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (ctrl_mult ? RUN : IDLE) :
              (state == RUN)  ? ((cnt == 5'd31) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      a <= '0;
      prod <= '0;
      cnt <= '0;
      data_result <= '0;
      data_resultRDY <= 1'b0;
      busy <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: if (ctrl_mult) begin
          a <= data_operandA;
          prod <= {32'd0, data_operandB, 1'b0};
          cnt <= '0;
          busy <= 1'b1;
        end
        RUN: begin
          prod <= {sum, prod[32:1]};
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          data_result <= prod[32:1];
          data_resultRDY <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
`ifdef MULT_OVERFLOW_DETECT_EN
  always_ff @(posedge clock)
    if (reset) data_exception <= 1'b0;
    else if (state == DONE) data_exception <= ~(&prod[64:32] | ~|prod[64:32]);
`else
  assign data_exception = 1'b0;
`endif
endmodule
